lab2_proc_xm_stage: RTL and testbench

LAB2_PROC_XM_STAGE -- requirements
Module: lab2_proc_xm_stage

---
 rtl/lab2_proc_xm_pkg.sv | 32 +++
 rtl/lab2_proc_xm_skid_buf.sv | 82 ++++++++
 rtl/lab2_proc_xm_stage.sv | 101 ++++++++++
 tb/tb_lab2_proc_xm_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_xm_pkg.sv
// Shared encodings and payload type for the X->M pipeline stage.
package lab2_proc_xm_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_type_e;

  typedef struct packed {
    logic [DataW-1:0]    alu_out;
    logic [RegAddrW-1:0] rf_waddr;
    logic                rf_wen;
    logic [1:0]          mem_type;
    logic [DataW-1:0]    wdata;
  } xm_payload_t;

endpackage

// File: rtl/lab2_proc_xm_skid_buf.sv
// Two-entry in-order buffer between X and M; head entry is always held in a register.
import lab2_proc_xm_pkg::*;

module lab2_proc_xm_skid_buf #(
  parameter int unsigned p_entries = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enq_val,
  input  xm_payload_t enq_data,
  input  logic        deq_rdy,
  output logic        deq_val,
  output xm_payload_t deq_data,
  output logic        full_next_c
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  xm_payload_t head_q, head_d;
  xm_payload_t tail_q, tail_d;
  logic        val_q, val_d;
  logic        deq_c;

  assign deq_c = val_q && deq_rdy;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (enq_val) begin
          state_d = ONE;
          head_d  = enq_data;
        end
      end
      ONE: begin
        if (enq_val && deq_c) begin
          head_d = enq_data;
        end else if (enq_val) begin
          state_d = TWO;
          tail_d  = enq_data;
        end else if (deq_c) begin
          state_d = EMPTY;
        end
      end
      // Upstream cannot enqueue while full, so only a drain is possible here.
      TWO: begin
        if (deq_c) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    val_d       = (state_d != EMPTY);
    full_next_c = (32'(state_d) >= p_entries);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      val_q   <= val_d;
    end
  end

  assign deq_val  = val_q;
  assign deq_data = head_q;

endmodule

// File: rtl/lab2_proc_xm_stage.sv
// X->M stage: resolves branches, raises a one-cycle fetch redirect and squashes the wrong-path slot.
import lab2_proc_xm_pkg::*;

module lab2_proc_xm_stage #(
  parameter int unsigned p_entries = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [DataW-1:0]    in_alu_out,
  input  logic                in_ops_eq,
  input  logic                in_ops_lt,
  input  logic                in_ops_ltu,
  input  logic [2:0]          in_br_type,
  input  logic [DataW-1:0]    in_br_target,
  input  logic [RegAddrW-1:0] in_rf_waddr,
  input  logic                in_rf_wen,
  input  logic [1:0]          in_mem_type,
  input  logic [DataW-1:0]    in_wdata,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [DataW-1:0]    out_alu_out,
  output logic [RegAddrW-1:0] out_rf_waddr,
  output logic                out_rf_wen,
  output logic [1:0]          out_mem_type,
  output logic [DataW-1:0]    out_wdata,
  output logic                redirect_val,
  output logic [DataW-1:0]    redirect_target
);

  logic             redirect_val_q, redirect_val_d;
  logic [DataW-1:0] redirect_target_q, redirect_target_d;
  logic             in_rdy_q, in_rdy_d;
  logic             taken_c, enq_c, full_next_c;
  xm_payload_t      in_pay_c, head_c;

  always_comb begin
    taken_c = 1'b0;
    unique case (br_type_e'(in_br_type))
      BR_NONE: taken_c = 1'b0;
      BR_BEQ:  taken_c = in_ops_eq;
      BR_BNE:  taken_c = !in_ops_eq;
      BR_BLT:  taken_c = in_ops_lt;
      BR_BGE:  taken_c = !in_ops_lt;
      BR_BLTU: taken_c = in_ops_ltu;
      BR_BGEU: taken_c = !in_ops_ltu;
      BR_JUMP: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  // A transfer during the redirect cycle is the wrong-path instruction and is dropped.
  always_comb begin
    in_pay_c          = '0;
    in_pay_c.alu_out  = in_alu_out;
    in_pay_c.rf_waddr = in_rf_waddr;
    in_pay_c.rf_wen   = in_rf_wen;
    in_pay_c.mem_type = in_mem_type;
    in_pay_c.wdata    = in_wdata;
    enq_c             = in_val && in_rdy_q && !redirect_val_q;
    redirect_val_d    = enq_c && taken_c;
    redirect_target_d = redirect_val_d ? in_br_target : redirect_target_q;
    in_rdy_d          = !full_next_c || redirect_val_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_val_q    <= 1'b0;
      redirect_target_q <= '0;
      in_rdy_q          <= 1'b0;
    end else begin
      redirect_val_q    <= redirect_val_d;
      redirect_target_q <= redirect_target_d;
      in_rdy_q          <= in_rdy_d;
    end
  end

  lab2_proc_xm_skid_buf #(
    .p_entries (p_entries)
  ) u_skid_buf (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (enq_c),
    .enq_data    (in_pay_c),
    .deq_rdy     (out_rdy),
    .deq_val     (out_val),
    .deq_data    (head_c),
    .full_next_c (full_next_c)
  );

  assign in_rdy          = in_rdy_q;
  assign redirect_val    = redirect_val_q;
  assign redirect_target = redirect_target_q;
  assign out_alu_out     = head_c.alu_out;
  assign out_rf_waddr    = head_c.rf_waddr;
  assign out_rf_wen      = head_c.rf_wen;
  assign out_mem_type    = head_c.mem_type;
  assign out_wdata       = head_c.wdata;

endmodule

// File: tb/tb_lab2_proc_xm_stage.sv
// Bench for lab2_proc_xm_stage: queue-based reference model plus directed literal checks.
import lab2_proc_xm_pkg::*;

module tb_lab2_proc_xm_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val, in_rdy;
  logic [31:0] in_alu_out;
  logic        in_ops_eq, in_ops_lt, in_ops_ltu;
  logic [2:0]  in_br_type;
  logic [31:0] in_br_target;
  logic [4:0]  in_rf_waddr;
  logic        in_rf_wen;
  logic [1:0]  in_mem_type;
  logic [31:0] in_wdata;
  logic        out_val, out_rdy;
  logic [31:0] out_alu_out;
  logic [4:0]  out_rf_waddr;
  logic        out_rf_wen;
  logic [1:0]  out_mem_type;
  logic [31:0] out_wdata;
  logic        redirect_val;
  logic [31:0] redirect_target;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  xm_payload_t m_q[$];
  bit          m_redir = 0;
  bit          m_rdy   = 0;
  bit          m_rst   = 0;
  logic [31:0] m_tgt   = '0;

  always #5 clk = ~clk;

  lab2_proc_xm_stage #(.p_entries(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_alu_out      (in_alu_out),
    .in_ops_eq       (in_ops_eq),
    .in_ops_lt       (in_ops_lt),
    .in_ops_ltu      (in_ops_ltu),
    .in_br_type      (in_br_type),
    .in_br_target    (in_br_target),
    .in_rf_waddr     (in_rf_waddr),
    .in_rf_wen       (in_rf_wen),
    .in_mem_type     (in_mem_type),
    .in_wdata        (in_wdata),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_alu_out     (out_alu_out),
    .out_rf_waddr    (out_rf_waddr),
    .out_rf_wen      (out_rf_wen),
    .out_mem_type    (out_mem_type),
    .out_wdata       (out_wdata),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_taken(input int br, input bit eq, input bit lt, input bit ltu);
    case (br)
      1: return eq;
      2: return !eq;
      3: return lt;
      4: return !lt;
      5: return ltu;
      6: return !ltu;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic compare();
    chk("in_rdy", 32'(in_rdy), 32'(m_rdy));
    chk("out_val", 32'(out_val), 32'(m_q.size() > 0));
    chk("redirect_val", 32'(redirect_val), 32'(m_redir));
    if (m_redir || m_rst) chk("redirect_target", redirect_target, m_tgt);
    if (m_q.size() > 0) begin
      chk("out_alu_out", out_alu_out, m_q[0].alu_out);
      chk("out_rf_waddr", 32'(out_rf_waddr), 32'(m_q[0].rf_waddr));
      chk("out_rf_wen", 32'(out_rf_wen), 32'(m_q[0].rf_wen));
      chk("out_mem_type", 32'(out_mem_type), 32'(m_q[0].mem_type));
      chk("out_wdata", out_wdata, m_q[0].wdata);
    end else if (m_rst) begin
      chk("rst_alu_out", out_alu_out, 32'd0);
      chk("rst_payload", {out_wdata[26:0], out_rf_waddr}, 32'd0);
      chk("rst_flags", 32'({out_rf_wen, out_mem_type}), 32'd0);
    end
  endtask

  // Advance model by one clock using the currently driven inputs, then check.
  task automatic step();
    bit          squash, xfer, nredir;
    xm_payload_t p;
    squash = m_redir;
    xfer   = in_val && m_rdy;
    if ((m_q.size() > 0) && out_rdy) void'(m_q.pop_front());
    nredir = 0;
    if (xfer && !squash) begin
      p.alu_out  = in_alu_out;
      p.rf_waddr = in_rf_waddr;
      p.rf_wen   = in_rf_wen;
      p.mem_type = in_mem_type;
      p.wdata    = in_wdata;
      m_q.push_back(p);
      nredir = is_taken(int'(in_br_type), in_ops_eq, in_ops_lt, in_ops_ltu);
      if (nredir) m_tgt = in_br_target;
    end
    m_redir = nredir;
    m_rdy   = (m_q.size() < 2) || m_redir;
    m_rst   = 0;
    if (!reset) begin
      m_q.delete();
      m_redir = 0;
      m_rdy   = 0;
      m_tgt   = '0;
      m_rst   = 1;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input logic [2:0] br, input bit eq, input bit lt,
                       input logic [31:0] tgt, input logic [31:0] alu);
    in_val       = v;
    in_br_type   = br;
    in_ops_eq    = eq;
    in_ops_lt    = lt;
    in_ops_ltu   = 1'b0;
    in_br_target = tgt;
    in_alu_out   = alu;
    in_rf_waddr  = alu[4:0];
    in_rf_wen    = 1'b1;
    in_mem_type  = 2'd0;
    in_wdata     = ~alu;
  endtask

  initial begin
    reset   = 1'b0;
    out_rdy = 1'b1;
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    chk("lit_rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("lit_rst_out_val", 32'(out_val), 32'd0);
    reset = 1'b1;
    step();
    chk("lit_post_rst_in_rdy", 32'(in_rdy), 32'd1);

    // beq taken
    drive(1, 3'd1, 1, 0, 32'h200, 32'h11);
    step();
    chk("lit_beq_redir", 32'(redirect_val), 32'd1);
    chk("lit_beq_target", redirect_target, 32'h200);
    chk("lit_beq_out", out_alu_out, 32'h11);
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    step();
    chk("lit_beq_redir_drop", 32'(redirect_val), 32'd0);

    // bge not taken
    drive(1, 3'd4, 0, 1, 32'h300, 32'h22);
    step();
    chk("lit_bge_redir", 32'(redirect_val), 32'd0);
    chk("lit_bge_out_val", 32'(out_val), 32'd1);
    chk("lit_bge_out", out_alu_out, 32'h22);
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    step();

    // Backpressure: third add blocked, then drains in order
    out_rdy = 1'b0;
    drive(1, 3'd0, 0, 0, 32'h0, 32'd1);
    step();
    drive(1, 3'd0, 0, 0, 32'h0, 32'd2);
    step();
    chk("lit_full_in_rdy", 32'(in_rdy), 32'd0);
    drive(1, 3'd0, 0, 0, 32'h0, 32'd3);
    step();
    chk("lit_full_head", out_alu_out, 32'd1);
    out_rdy = 1'b1;
    step();
    chk("lit_drain_2", out_alu_out, 32'd2);
    step();
    chk("lit_drain_3", out_alu_out, 32'd3);
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    step();
    chk("lit_drain_empty", 32'(out_val), 32'd0);

    // Jump then wrong-path add squashed
    drive(1, 3'd7, 0, 0, 32'h440, 32'h77);
    step();
    chk("lit_jump_redir", 32'(redirect_val), 32'd1);
    chk("lit_jump_out", out_alu_out, 32'h77);
    drive(1, 3'd0, 0, 0, 32'h0, 32'h55);
    step();
    chk("lit_squash_out_val", 32'(out_val), 32'd0);
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    step();

    // Reset while full
    out_rdy = 1'b0;
    drive(1, 3'd0, 0, 0, 32'h0, 32'h61);
    step();
    drive(1, 3'd0, 0, 0, 32'h0, 32'h62);
    step();
    drive(0, 3'd0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    chk("lit_midrst_out_val", 32'(out_val), 32'd0);
    chk("lit_midrst_in_rdy", 32'(in_rdy), 32'd0);
    reset = 1'b1;
    step();
    chk("lit_midrst_recover", 32'(in_rdy), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      in_val       = 1'($urandom_range(0, 1));
      in_br_type   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      in_ops_eq    = 1'($urandom_range(0, 1));
      in_ops_lt    = 1'($urandom_range(0, 1));
      in_ops_ltu   = 1'($urandom_range(0, 1));
      in_br_target = $urandom;
      in_alu_out   = $urandom;
      in_rf_waddr  = 5'($urandom_range(0, 31));
      in_rf_wen    = 1'($urandom_range(0, 1));
      in_mem_type  = 2'($urandom_range(0, 2));
      in_wdata     = $urandom;
      out_rdy      = ($urandom_range(0, 2) != 0);
      reset        = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
